mem_arbiter: RTL

Sequencer and arbiter for the single memory port (MAR, MEM, MDR, MFC handshake) of the microcontroller. It shares that port between the instruction-fetch requester and the data load/store requester. It drives MAR load, MDR write, memEn and R_W in the correct order, and waits on MFC. It returns read data and a one-cycle completion pulse to the granted requester.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_wdog.sv | 31 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, requester ids,
// R_W encoding and the round-robin pick used when both requesters want the port.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic REQ_IF   = 1'b0;
  localparam logic REQ_DM   = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A lone request wins; on a tie the requester not granted last time wins.
  function automatic logic rr_pick(input logic if_req, input logic dm_req, input logic last);
    if (if_req && !dm_req) return REQ_IF;
    if (!if_req && dm_req) return REQ_DM;
    return (last == REQ_DM) ? REQ_IF : REQ_DM;
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// MFC wait watchdog: counts ACCESS cycles and flags the cycle that is the LIMIT-th one.
module mem_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the number of ACCESS cycles already completed before this one.
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer for the single MAR/MDR/MFC memory port shared by fetch and data.
// Optional MFC timeout watchdog is built when MEM_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mar_load,
  output logic [DATA_W-1:0] mdr_wdata,
  output logic              mdr_write_en,
  output logic              mem_en,
  output logic              r_w,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mfc,
  output logic              busy,
  output logic              err
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic wdog_expired;

  mem_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == ADDR),
    .en      (state_q == ACCESS),
    .expired (wdog_expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_d = rr_pick(if_req, dm_req, last_q);
          last_d  = owner_d;
          addr_d  = (owner_d == REQ_IF) ? if_addr : dm_addr;
          we_d    = (owner_d == REQ_DM) && dm_we;
          wdata_d = (owner_d == REQ_DM) ? dm_wdata : '0;
          state_d = ADDR;
        end
      end
      ADDR: state_d = ACCESS;
      ACCESS: begin
        if (mfc) begin
          state_d = RESP;
          if (!we_q) rdata_d = mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wdog_expired) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ_IF;
      last_q  <= REQ_DM;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Every port output decodes from registered state; nothing passes through from req or mfc.
  assign busy         = (state_q != IDLE);
  assign if_gnt       = busy && (owner_q == REQ_IF);
  assign dm_gnt       = busy && (owner_q == REQ_DM);
  assign if_done      = (state_q == RESP) && (owner_q == REQ_IF);
  assign dm_done      = (state_q == RESP) && (owner_q == REQ_DM);
  assign mar_addr     = addr_q;
  assign mar_load     = (state_q == ADDR);
  assign mdr_wdata    = wdata_q;
  assign mdr_write_en = (state_q == ADDR) && we_q;
  assign mem_en       = (state_q == ACCESS);
  assign r_w          = (state_q == ACCESS) ? (we_q ? RW_WRITE : RW_READ) : 1'b0;
  assign rdata        = rdata_q;

`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
